// File: rtl/mips_seq_ctrl.sv
// Multi-cycle sequencer for a simple MIPS-style core.
// Walks FETCH -> DECODE -> EXEC -> WB per instruction, latches the fetched
// word into IR, and emits register-file and PC strobes during write-back.
module mips_seq_ctrl #(
   parameter logic [5:0] OP_BEQZ = 6'h3E,
   parameter logic [5:0] OP_HALT = 6'h3F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [63:0] instr,
   input  logic        alu_zero,
   output logic [5:0]  rf_ra1,
   output logic [5:0]  rf_ra2,
   output logic [5:0]  rf_wa,
   output logic [5:0]  alu_ctrl,
   output logic        rf_we,
   output logic        pc_inc,
   output logic        pc_load,
   output logic [15:0] pc_target,
   output logic        busy,
   output logic        halted,
   output logic [15:0] instr_count
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StWb,
      StHalt
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] ir_q, ir_d;
   logic        zero_flag_q, zero_flag_d;
   logic [15:0] instr_count_q, instr_count_d;

   logic imem_req_q, imem_req_d;
   logic rf_we_q, rf_we_d;
   logic pc_inc_q, pc_inc_d;
   logic pc_load_q, pc_load_d;
   logic busy_q, busy_d;
   logic halted_q, halted_d;
   logic wb_is_beqz;

   // Next-state, IR capture, zero-flag sampling and retire counter.
   always_comb begin
      state_d       = state_q;
      ir_d          = ir_q;
      zero_flag_d   = zero_flag_q;
      instr_count_d = instr_count_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StFetch;
         end
         StFetch: begin
            if (imem_ack) begin
               ir_d    = instr;
               state_d = StDecode;
            end
         end
         StDecode: begin
            state_d = (ir_q[5:0] == OP_HALT) ? StHalt : StExec;
         end
         StExec: begin
            zero_flag_d = alu_zero;
            state_d     = StWb;
         end
         StWb: begin
            if (instr_count_q != 16'hFFFF) instr_count_d = instr_count_q + 16'd1;
            state_d = StFetch;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are decoded from the next state so they can be registered
   // while still lining up with the state they belong to.
   always_comb begin
      wb_is_beqz = (ir_d[5:0] == OP_BEQZ);
      imem_req_d = (state_d == StFetch);
      busy_d     = (state_d == StFetch) || (state_d == StDecode) ||
                   (state_d == StExec)  || (state_d == StWb);
      halted_d   = (state_d == StHalt);
      rf_we_d    = 1'b0;
      pc_inc_d   = 1'b0;
      pc_load_d  = 1'b0;
      if (state_d == StWb) begin
         // HALT never reaches WB, so anything not BEQZ is an ALU op.
         rf_we_d   = !wb_is_beqz;
         pc_load_d = wb_is_beqz && zero_flag_d;
         pc_inc_d  = !(wb_is_beqz && zero_flag_d);
      end
   end

   // Single state register; synchronous reset dominates every transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         ir_q          <= '0;
         zero_flag_q   <= 1'b0;
         instr_count_q <= '0;
         imem_req_q    <= 1'b0;
         rf_we_q       <= 1'b0;
         pc_inc_q      <= 1'b0;
         pc_load_q     <= 1'b0;
         busy_q        <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         zero_flag_q   <= zero_flag_d;
         instr_count_q <= instr_count_d;
         imem_req_q    <= imem_req_d;
         rf_we_q       <= rf_we_d;
         pc_inc_q      <= pc_inc_d;
         pc_load_q     <= pc_load_d;
         busy_q        <= busy_d;
         halted_q      <= halted_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign rf_we       = rf_we_q;
   assign pc_inc      = pc_inc_q;
   assign pc_load     = pc_load_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign instr_count = instr_count_q;

   assign rf_ra1    = ir_q[17:12];
   assign rf_ra2    = ir_q[23:18];
   assign rf_wa     = ir_q[11:6];
   assign alu_ctrl  = ir_q[5:0];
   assign pc_target = ir_q[39:24];

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Randomized bench for mips_seq_ctrl with a transaction-level reference:
// each instruction is expected to show FETCH (plus stall cycles), DECODE,
// EXEC and WB phases with strobes derived from its opcode and zero flag.
module tb_mips_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        imem_ack;
   logic [63:0] instr;
   logic        alu_zero;
   logic        imem_req;
   logic [5:0]  rf_ra1, rf_ra2, rf_wa, alu_ctrl;
   logic        rf_we, pc_inc, pc_load, busy, halted;
   logic [15:0] pc_target, instr_count;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_ir;
   logic [15:0] exp_cnt;

   localparam logic [5:0] OUT_IDLE  = 6'b000000;
   localparam logic [5:0] OUT_FETCH = 6'b100010;
   localparam logic [5:0] OUT_BUSY  = 6'b000010;
   localparam logic [5:0] OUT_HALT  = 6'b000001;

   // {imem_req, rf_we, pc_inc, pc_load, busy, halted}
   wire [5:0]  outs    = {imem_req, rf_we, pc_inc, pc_load, busy, halted};
   wire [39:0] ir_view = {pc_target, rf_ra2, rf_ra1, rf_wa, alu_ctrl};

   mips_seq_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .imem_req   (imem_req),
      .imem_ack   (imem_ack),
      .instr      (instr),
      .alu_zero   (alu_zero),
      .rf_ra1     (rf_ra1),
      .rf_ra2     (rf_ra2),
      .rf_wa      (rf_wa),
      .alu_ctrl   (alu_ctrl),
      .rf_we      (rf_we),
      .pc_inc     (pc_inc),
      .pc_load    (pc_load),
      .pc_target  (pc_target),
      .busy       (busy),
      .halted     (halted),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] mk_word(input logic [5:0] op, input logic [15:0] tgt);
      logic [63:0] w;
      w        = {$urandom, $urandom};
      w[39:24] = tgt;
      w[5:0]   = op;
      return w;
   endfunction

   function automatic logic [5:0] rand_alu_op();
      return 6'($urandom_range(0, 61));
   endfunction

   // Reset from whatever state; leaves DUT in IDLE with model cleared.
   task automatic do_reset();
      rst      = 1'b1;
      start    = 1'($urandom_range(0, 1));
      imem_ack = 1'b1;
      instr    = {$urandom, $urandom};
      alu_zero = 1'($urandom_range(0, 1));
      tick();
      rst      = 1'b0;
      start    = 1'b0;
      imem_ack = 1'b0;
      exp_ir   = '0;
      exp_cnt  = '0;
      checks++;
      if (outs !== OUT_IDLE || ir_view !== 40'd0 || instr_count !== 16'd0) begin
         errors++;
         $display("FAIL reset: outs=%b ir=%h cnt=%0d, want outs=%b ir=0 cnt=0",
                  outs, ir_view, instr_count, OUT_IDLE);
      end
   endtask

   // Pulse start in IDLE; DUT must be in FETCH the next cycle.
   task automatic begin_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (outs !== OUT_FETCH) begin
         errors++;
         $display("FAIL idle_to_fetch: outs=%b want %b", outs, OUT_FETCH);
      end
   endtask

   // Entered in FETCH; drives one instruction through and checks every phase.
   task automatic run_instr(input logic [63:0] word, input int stall, input logic z,
                            input logic hold_start);
      logic [5:0] exp_o;
      logic       beqz;
      for (int i = 0; i <= stall; i++) begin
         checks++;
         if (outs !== OUT_FETCH || ir_view !== exp_ir[39:0]) begin
            errors++;
            $display("FAIL fetch_wait%0d: outs=%b ir=%h want outs=%b ir=%h",
                     i, outs, ir_view, OUT_FETCH, exp_ir[39:0]);
         end
         imem_ack = (i == stall);
         instr    = (i == stall) ? word : {$urandom, $urandom};
         start    = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
         alu_zero = 1'($urandom_range(0, 1));
         tick();
      end
      exp_ir   = word;
      checks++;
      if (outs !== OUT_BUSY || ir_view !== word[39:0]) begin
         errors++;
         $display("FAIL decode: outs=%b ir=%h want outs=%b ir=%h",
                  outs, ir_view, OUT_BUSY, word[39:0]);
      end
      imem_ack = 1'($urandom_range(0, 1));
      instr    = {$urandom, $urandom};
      tick();
      if (word[5:0] == 6'h3F) begin
         checks++;
         if (outs !== OUT_HALT || instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL halt_entry: outs=%b cnt=%0d want outs=%b cnt=%0d",
                     outs, instr_count, OUT_HALT, exp_cnt);
         end
      end else begin
         checks++;
         if (outs !== OUT_BUSY) begin
            errors++;
            $display("FAIL exec: outs=%b want %b", outs, OUT_BUSY);
         end
         imem_ack = 1'($urandom_range(0, 1));
         alu_zero = z;
         tick();
         beqz  = (word[5:0] == 6'h3E);
         exp_o = {1'b0, !beqz, !(beqz && z), beqz && z, 1'b1, 1'b0};
         checks++;
         if (outs !== exp_o || pc_target !== word[39:24]) begin
            errors++;
            $display("FAIL wb op=%h z=%0d: outs=%b tgt=%h want outs=%b tgt=%h",
                     word[5:0], z, outs, pc_target, exp_o, word[39:24]);
         end
         alu_zero = !z;
         tick();
         exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
         checks++;
         if (outs !== OUT_FETCH || instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL retire: outs=%b cnt=%0d want outs=%b cnt=%0d",
                     outs, instr_count, OUT_FETCH, exp_cnt);
         end
      end
      start    = 1'b0;
      imem_ack = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         imem_ack = 1'b1;
         instr    = {$urandom, $urandom};
         tick();
         checks++;
         if (outs !== OUT_IDLE || ir_view !== 40'd0) begin
            errors++;
            $display("FAIL idle_hold%0d: outs=%b ir=%h want outs=0 ir=0", i, outs, ir_view);
         end
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_alu();
      do_reset();
      begin_run();
      run_instr(mk_word(6'h02, 16'($urandom)), 0, 1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic test_stall();
      run_instr(mk_word(rand_alu_op(), 16'($urandom)), 3, 1'b0, 1'b0);
   endtask

   task automatic test_beqz();
      run_instr(mk_word(6'h3E, 16'h0123), 0, 1'b1, 1'b0);
      run_instr(mk_word(6'h3E, 16'h0123), 1, 1'b0, 1'b0);
   endtask

   task automatic test_halt();
      do_reset();
      begin_run();
      run_instr(mk_word(rand_alu_op(), 16'($urandom)), 0, 1'b0, 1'b0);
      run_instr(mk_word(rand_alu_op(), 16'($urandom)), 1, 1'b1, 1'b0);
      run_instr(mk_word(6'h3F, 16'($urandom)), 0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         start    = 1'($urandom_range(0, 1));
         imem_ack = 1'b1;
         instr    = {$urandom, $urandom};
         tick();
         checks++;
         if (outs !== OUT_HALT || ir_view !== exp_ir[39:0] || instr_count !== 16'd2) begin
            errors++;
            $display("FAIL halt_hold%0d: outs=%b ir=%h cnt=%0d want outs=%b ir=%h cnt=2",
                     i, outs, ir_view, instr_count, OUT_HALT, exp_ir[39:0]);
         end
      end
      start    = 1'b0;
      imem_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      // Reset while in WB: the retire increment must not happen.
      do_reset();
      begin_run();
      imem_ack = 1'b1;
      instr    = mk_word(6'h02, 16'hBEEF);
      tick();
      imem_ack = 1'b0;
      tick();
      tick();
      checks++;
      if (rf_we !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_wb: rf_we=%b want 1", rf_we);
      end
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      checks++;
      if (outs !== OUT_IDLE || ir_view !== 40'd0 || instr_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_in_wb: outs=%b ir=%h cnt=%0d want all 0",
                  outs, ir_view, instr_count);
      end
      // Reset while in FETCH with a valid ack: IR must not capture.
      begin_run();
      rst      = 1'b1;
      start    = 1'b1;
      imem_ack = 1'b1;
      instr    = mk_word(6'h05, 16'hFFFF);
      tick();
      rst      = 1'b0;
      start    = 1'b0;
      imem_ack = 1'b0;
      checks++;
      if (outs !== OUT_IDLE || ir_view !== 40'd0 || instr_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_in_fetch: outs=%b ir=%h cnt=%0d want all 0",
                  outs, ir_view, instr_count);
      end
      exp_ir  = '0;
      exp_cnt = '0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      begin_run();
      for (int i = 0; i < 3; i++) begin
         run_instr(mk_word(rand_alu_op(), 16'($urandom)), 0, 1'($urandom_range(0, 1)), 1'b1);
      end
      checks++;
      if (instr_count !== 16'd3) begin
         errors++;
         $display("FAIL back_to_back_count: cnt=%0d want 3", instr_count);
      end
   endtask

   task automatic test_random();
      logic [5:0] op;
      do_reset();
      begin_run();
      for (int i = 0; i < 25; i++) begin
         op = ($urandom_range(0, 3) == 0) ? 6'h3E : rand_alu_op();
         run_instr(mk_word(op, 16'($urandom)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'b0);
      end
      run_instr(mk_word(6'h3F, 16'($urandom)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
      checks++;
      if (instr_count !== 16'd25 || halted !== 1'b1) begin
         errors++;
         $display("FAIL random_final: cnt=%0d halted=%b want cnt=25 halted=1",
                  instr_count, halted);
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      imem_ack = 1'b0;
      instr    = '0;
      alu_zero = 1'b0;
      exp_ir   = '0;
      exp_cnt  = '0;
      tick();
      tick();
      test_reset();
      test_alu();
      test_stall();
      test_beqz();
      test_halt();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_seq_ctrl.md
MIPS_SEQ_CTRL -- requirements
Module: mips_seq_ctrl

Interface
REQ-001 SHALL declare parameters, one per line (name, default, meaning):
  - OP_BEQZ, 6'h3E, opcode for branch-if-zero.
  - OP_HALT, 6'h3F, opcode for halt.
REQ-002 SHALL declare ports, one per line (name, direction, width, meaning):
  - clk, input, 1, single clock; all state updates on its rising edge.
  - rst, input, 1, synchronous, active-high reset.
  - start, input, 1, begin execution from IDLE.
  - imem_req, output, 1, instruction fetch request.
  - imem_ack, input, 1, fetch data valid this cycle.
  - instr, input, 64, instruction word from instruction memory.
  - alu_zero, input, 1, ALU zero flag.
  - rf_ra1, output, 6, register read address 1 = IR[17:12].
  - rf_ra2, output, 6, register read address 2 = IR[23:18].
  - rf_wa, output, 6, register write address = IR[11:6].
  - alu_ctrl, output, 6, ALU control = IR[5:0].
  - rf_we, output, 1, register-file write enable.
  - pc_inc, output, 1, advance program counter by one.
  - pc_load, output, 1, load program counter with pc_target.
  - pc_target, output, 16, branch target = IR[39:24].
  - busy, output, 1, high in FETCH, DECODE, EXEC and WB.
  - halted, output, 1, high in HALT.
  - instr_count, output, 16, retired-instruction counter.
REQ-003 SHALL use one clock (clk) and a synchronous, active-high reset (rst); no asynchronous logic.

Function
REQ-004 SHALL implement states IDLE, FETCH, DECODE, EXEC, WB, HALT, with exactly one state active per cycle.
REQ-005 IDLE: start=1 -> FETCH next cycle; start=0 -> remain in IDLE.
REQ-006 start SHALL be ignored in every state other than IDLE.
REQ-007 FETCH: imem_req=1 combinationally in this state only.
  - On imem_ack=1: IR<=instr, go to DECODE.
  - On imem_ack=0: remain in FETCH with no timeout.
  - imem_ack outside FETCH SHALL be ignored.
REQ-008 DECODE: IR[5:0]==OP_HALT -> HALT; otherwise -> EXEC.
  - No outputs other than busy and the IR-field outputs are asserted in DECODE.
REQ-009 EXEC: alu_zero SHALL be sampled into an internal zero_flag at the end of the cycle, then go to WB.
REQ-010 WB, ALU operation (opcode not OP_BEQZ/OP_HALT): rf_we=1 and pc_inc=1 for exactly this one cycle.
REQ-011 WB, OP_BEQZ: rf_we=0.
  - zero_flag=1 -> pc_load=1, pc_inc=0.
  - zero_flag=0 -> pc_inc=1, pc_load=0.
REQ-012 pc_inc and pc_load SHALL never be high in the same cycle; both SHALL be low outside WB.
REQ-013 WB SHALL increment instr_count by 1 (saturating at 16'hFFFF), then go to FETCH.
REQ-014 HALT: halted=1, busy=0, no PC or register-file strobes; exit only via rst.
  - The HALT instruction itself does not increment instr_count.
REQ-015 rf_ra1, rf_ra2, rf_wa, alu_ctrl and pc_target SHALL be driven from IR in all states; IR changes only on an accepted fetch.
REQ-016 Instruction latency without fetch stall SHALL be 4 cycles (FETCH, DECODE, EXEC, WB); each FETCH wait cycle adds one.

Reset
REQ-017 rst=1 at a clock edge SHALL force, from any state including mid-fetch and WB:
  - state=IDLE, IR=0, zero_flag=0, instr_count=0.
  - All outputs 0: imem_req, rf_we, pc_inc, pc_load, busy, halted.
REQ-018 rst SHALL take priority over start, imem_ack and all state transitions in the same cycle.

Verification
REQ-019 Reset then start pulse, imem_ack=1 immediately, instr[5:0]=6'h02 -> imem_req for 1 cycle; rf_we=1 and pc_inc=1 exactly in the 4th cycle after start is sampled; instr_count=1.
REQ-020 imem_ack withheld 3 cycles in FETCH -> imem_req held high 4 cycles; IR, rf_we, pc_inc unchanged until ack; latency 7 cycles.
REQ-021 OP_BEQZ with IR[39:24]=16'h0123:
  - alu_zero=1 in EXEC -> pc_load=1, pc_target=16'h0123, pc_inc=0, rf_we=0 in WB.
  - alu_zero=0 -> pc_inc=1, pc_load=0.
REQ-022 OP_HALT fetched after two ALU instructions -> halted=1, busy=0, instr_count=2; start pulses and imem_ack ignored thereafter.
REQ-023 rst asserted during WB, and separately during FETCH with imem_ack=1 -> next cycle state IDLE, all outputs 0, IR=0, instr_count=0.
REQ-024 start held high continuously across 3 instructions -> no re-entry or glitch in sequencing; instr_count=3 after third WB.
